// File: rtl/indianpoker_betting_ctrl_n.sv
// N-player Indian-poker round controller: deals cards, runs sequential betting,
// then settles the pot to the highest card or refunds every bet on a tie.
module indianpoker_betting_ctrl_n #(
    parameter int         NUM_PLAYERS = 2,
    parameter int         CHIP_W      = 8,
    parameter int         START_CHIPS = 10,
    parameter int         CARD_MAX    = 10,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          Up,
    input  logic                          Down,
    input  logic                          set,
    input  logic                          card_ld,
    input  logic [8*NUM_PLAYERS-1:0]      card_in,
    output logic [1:0]                    state,
    output logic [2:0]                    cur_player,
    output logic [CHIP_W-1:0]             cur_bet,
    output logic [8*NUM_PLAYERS-1:0]      cards,
    output logic [CHIP_W*NUM_PLAYERS-1:0] chips,
    output logic [CHIP_W-1:0]             pot,
    output logic [2:0]                    winner,
    output logic                          win_pulse,
    output logic                          tie_pulse,
    output logic                          game_over
);

    typedef enum logic [1:0] {
        DEAL   = 2'b00,
        BET    = 2'b01,
        SETTLE = 2'b10,
        OVER   = 2'b11
    } state_t;

    localparam logic [7:0]        CARD_MAX_B  = 8'(CARD_MAX);
    localparam logic [CHIP_W-1:0] START_VAL   = CHIP_W'(START_CHIPS);
    localparam logic [CHIP_W-1:0] ONE_CHIP    = CHIP_W'(1);

    state_t                  r_state;
    logic [7:0]              r_cards [NUM_PLAYERS];
    logic [CHIP_W-1:0]       r_chips [NUM_PLAYERS];
    logic [CHIP_W-1:0]       r_bet   [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]  r_active;
    logic [CHIP_W-1:0]       r_pot;
    logic [CHIP_W-1:0]       r_curBet;
    logic [2:0]              r_curPlayer;
    logic [2:0]              r_winner;
    logic                    r_winPulse;
    logic                    r_tiePulse;
    logic                    r_gameOver;
    logic [7:0]              r_lfsr;
    logic                    r_upS, r_upP, r_downS, r_downP, r_setS, r_setP;

    logic                    w_upEdge, w_downEdge, w_setEdge;
    logic [7:0]              w_lfsrNext;
    logic [7:0]              w_rot      [NUM_PLAYERS];
    logic [7:0]              w_forced   [NUM_PLAYERS];
    logic [7:0]              w_dealCard [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]  w_dealActive;
    logic [2:0]              w_firstActive;
    logic [CHIP_W-1:0]       w_curChips;
    logic [2:0]              w_nextPlayer;
    logic                    w_hasNext;
    logic [7:0]              w_maxCard;
    logic [3:0]              w_maxCount;
    logic [2:0]              w_winIdx;
    logic                    w_unique;
    logic [CHIP_W-1:0]       w_settleChips [NUM_PLAYERS];
    logic [3:0]              w_aliveCount;

    assign w_upEdge   = r_upS & ~r_upP;
    assign w_downEdge = r_downS & ~r_downP;
    assign w_setEdge  = r_setS & ~r_setP;
    assign w_lfsrNext = {r_lfsr[6:0], 1'b0} ^ (r_lfsr[7] ? 8'h71 : 8'h00);

    // Deal candidates: players holding chips get a forced (clamped) or LFSR card
    always_comb begin
        w_firstActive = 3'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            w_dealActive[i] = (r_chips[i] != '0);
            w_rot[i]        = (r_lfsr << i) | (r_lfsr >> (8 - i));
            w_forced[i]     = card_in[8*i +: 8];
            if (w_forced[i] == 8'd0 || w_forced[i] > CARD_MAX_B)
                w_forced[i] = CARD_MAX_B;
            if (!w_dealActive[i])
                w_dealCard[i] = 8'd0;
            else if (card_ld)
                w_dealCard[i] = w_forced[i];
            else
                w_dealCard[i] = (w_rot[i] % CARD_MAX_B) + 8'd1;
            if (w_dealActive[i])
                w_firstActive = 3'(i);
        end
    end

    always_comb begin
        w_curChips   = '0;
        w_nextPlayer = r_curPlayer;
        w_hasNext    = 1'b0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (3'(i) == r_curPlayer)
                w_curChips = r_chips[i];
            if (i > int'(r_curPlayer) && r_active[i]) begin
                w_nextPlayer = 3'(i);
                w_hasNext    = 1'b1;
            end
        end
    end

    // Settlement only depends on cards, so it is valid both on entry to and during SETTLE
    always_comb begin
        w_maxCard    = 8'd0;
        w_maxCount   = 4'd0;
        w_winIdx     = 3'd0;
        w_aliveCount = 4'd0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (r_active[i] && r_cards[i] > w_maxCard)
                w_maxCard = r_cards[i];
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (r_active[i] && r_cards[i] == w_maxCard) begin
                w_maxCount = w_maxCount + 4'd1;
                w_winIdx   = 3'(i);
            end
        w_unique = (w_maxCount == 4'd1);
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_unique)
                w_settleChips[i] = (3'(i) == w_winIdx) ? r_chips[i] + r_pot : r_chips[i];
            else
                w_settleChips[i] = r_chips[i] + r_bet[i];
            if (w_settleChips[i] != '0)
                w_aliveCount = w_aliveCount + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state     <= DEAL;
            r_active    <= '0;
            r_pot       <= '0;
            r_curBet    <= ONE_CHIP;
            r_curPlayer <= 3'd0;
            r_winner    <= 3'd0;
            r_winPulse  <= 1'b0;
            r_tiePulse  <= 1'b0;
            r_gameOver  <= 1'b0;
            r_lfsr      <= LFSR_SEED;
            r_upS       <= 1'b0;
            r_upP       <= 1'b0;
            r_downS     <= 1'b0;
            r_downP     <= 1'b0;
            r_setS      <= 1'b0;
            r_setP      <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_cards[i] <= 8'd0;
                r_chips[i] <= START_VAL;
                r_bet[i]   <= '0;
            end
        end else begin
            r_lfsr  <= w_lfsrNext;
            r_upS   <= Up;
            r_upP   <= r_upS;
            r_downS <= Down;
            r_downP <= r_downS;
            r_setS  <= set;
            r_setP  <= r_setS;
            case (r_state)
                DEAL: begin
                    for (int i = 0; i < NUM_PLAYERS; i++)
                        r_cards[i] <= w_dealCard[i];
                    r_active    <= w_dealActive;
                    r_curPlayer <= w_firstActive;
                    r_curBet    <= ONE_CHIP;
                    r_state     <= BET;
                end
                BET: begin
                    if (w_setEdge) begin
                        for (int i = 0; i < NUM_PLAYERS; i++)
                            if (3'(i) == r_curPlayer) begin
                                r_bet[i]   <= r_curBet;
                                r_chips[i] <= r_chips[i] - r_curBet;
                            end
                        r_pot    <= r_pot + r_curBet;
                        r_curBet <= ONE_CHIP;
                        if (w_hasNext) begin
                            r_curPlayer <= w_nextPlayer;
                        end else begin
                            r_state <= SETTLE;
                            if (w_unique) begin
                                r_winner   <= w_winIdx;
                                r_winPulse <= 1'b1;
                            end else begin
                                r_tiePulse <= 1'b1;
                            end
                        end
                    end else if (w_upEdge && !w_downEdge) begin
                        if (r_curBet < w_curChips)
                            r_curBet <= r_curBet + ONE_CHIP;
                    end else if (w_downEdge && !w_upEdge) begin
                        if (r_curBet > ONE_CHIP)
                            r_curBet <= r_curBet - ONE_CHIP;
                    end
                end
                SETTLE: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        r_chips[i] <= w_settleChips[i];
                        r_bet[i]   <= '0;
                    end
                    r_pot      <= '0;
                    r_winPulse <= 1'b0;
                    r_tiePulse <= 1'b0;
                    if (w_aliveCount <= 4'd1) begin
                        r_state    <= OVER;
                        r_gameOver <= 1'b1;
                    end else begin
                        r_state <= DEAL;
                    end
                end
                OVER: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign cards[8*g +: 8]          = r_cards[g];
        assign chips[CHIP_W*g +: CHIP_W] = r_chips[g];
    end

    assign state      = r_state;
    assign cur_player = r_curPlayer;
    assign cur_bet    = r_curBet;
    assign pot        = r_pot;
    assign winner     = r_winner;
    assign win_pulse  = r_winPulse;
    assign tie_pulse  = r_tiePulse;
    assign game_over  = r_gameOver;

endmodule

// File: tb/tb_indianpoker_betting_ctrl_n.sv
// Bench for the Indian-poker controller: directed table and sequences on a
// two-player and a three-player instance, then random rounds against a game model.
module tb_indianpoker_betting_ctrl_n;

    localparam int N2 = 2;
    localparam int N3 = 3;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        btnUp = 1'b0;
    logic        btnDown = 1'b0;
    logic        btnSet = 1'b0;
    logic        cardLd = 1'b1;
    logic [15:0] cardIn2 = 16'h0;
    logic [23:0] cardIn3 = 24'h0;

    logic [1:0]  state2, state3;
    logic [2:0]  curPlayer2, curPlayer3, winner2, winner3;
    logic [7:0]  curBet2, curBet3, pot2, pot3;
    logic [15:0] cards2, chips2;
    logic [23:0] cards3, chips3;
    logic        winPulse2, tiePulse2, gameOver2;
    logic        winPulse3, tiePulse3, gameOver3;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc;

    indianpoker_betting_ctrl_n #(.NUM_PLAYERS(N2)) dut2 (
        .CLK(CLK), .CLR(CLR), .Up(btnUp), .Down(btnDown), .set(btnSet),
        .card_ld(cardLd), .card_in(cardIn2), .state(state2),
        .cur_player(curPlayer2), .cur_bet(curBet2), .cards(cards2),
        .chips(chips2), .pot(pot2), .winner(winner2), .win_pulse(winPulse2),
        .tie_pulse(tiePulse2), .game_over(gameOver2)
    );

    indianpoker_betting_ctrl_n #(.NUM_PLAYERS(N3)) dut3 (
        .CLK(CLK), .CLR(CLR), .Up(btnUp), .Down(btnDown), .set(btnSet),
        .card_ld(cardLd), .card_in(cardIn3), .state(state3),
        .cur_player(curPlayer3), .cur_bet(curBet3), .cards(cards3),
        .chips(chips3), .pot(pot3), .winner(winner3), .win_pulse(winPulse3),
        .tie_pulse(tiePulse3), .game_over(gameOver3)
    );

    always #5 CLK = ~CLK;

    // Edges since reset release, used to predict the LFSR value at each deal
    always @(posedge CLK or posedge CLR) begin
        if (CLR) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int chip2(input int i);
        return int'(chips2[8*i +: 8]);
    endfunction
    function automatic int card2(input int i);
        return int'(cards2[8*i +: 8]);
    endfunction
    function automatic int chip3(input int i);
        return int'(chips3[8*i +: 8]);
    endfunction
    function automatic int card3(input int i);
        return int'(cards3[8*i +: 8]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkInvariant();
        checkOutput("invariant2", chip2(0) + chip2(1) + int'(pot2), 20);
        checkOutput("invariant3", chip3(0) + chip3(1) + chip3(2) + int'(pot3), 30);
    endtask

    // One button press: high for one cycle, low for one; its effect is visible on return
    task automatic applyStimulus(input logic u, input logic d, input logic s);
        btnUp = u; btnDown = d; btnSet = s;
        tick();
        btnUp = 1'b0; btnDown = 1'b0; btnSet = 1'b0;
        tick();
        checkInvariant();
    endtask

    task automatic resetDuts(input int cycles);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (cycles) tick();
        CLR = 1'b0;
    endtask

    // ---------------- behavioural game model (two players) ----------------
    int mChips [N2];
    int mBet   [N2];
    int mCards [N2];
    bit mActive[N2];
    int mPot, mCur, mCurBet, mWinner, mState;
    bit mWin, mTie, mLd;

    function automatic int lfsrAfter(input int n);
        int v = 'hA5;
        for (int k = 0; k < n; k++) begin
            v = v << 1;
            if ((v & 'h100) != 0) v = v ^ 'h171;
        end
        return v;
    endfunction

    function automatic int rotl8(input int v, input int sh);
        return ((v << sh) | (v >> (8 - sh))) & 'hFF;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N2; i++) begin
            mChips[i] = 10; mBet[i] = 0; mCards[i] = 0; mActive[i] = 0;
        end
        mPot = 0; mCur = 0; mCurBet = 1; mWinner = 0; mState = 0; mWin = 0; mTie = 0;
    endtask

    task automatic modelDeal(input int lf);
        int raw;
        mCur = -1;
        for (int i = 0; i < N2; i++) begin
            mActive[i] = (mChips[i] > 0);
            raw = int'(cardIn2[8*i +: 8]);
            if (!mActive[i])  mCards[i] = 0;
            else if (mLd)     mCards[i] = (raw == 0 || raw > 10) ? 10 : raw;
            else              mCards[i] = (rotl8(lf, i) % 10) + 1;
            if (mActive[i] && mCur < 0) mCur = i;
        end
        mCurBet = 1;
        mState = 1;
    endtask

    task automatic modelAdjust(input bit u, input bit d);
        if (u && !d && mCurBet < mChips[mCur]) mCurBet++;
        if (d && !u && mCurBet > 1) mCurBet--;
    endtask

    task automatic modelCommit();
        int nxt = -1;
        int maxCard = 0;
        int holders = 0;
        int holder = 0;
        mBet[mCur] = mCurBet;
        mChips[mCur] -= mCurBet;
        mPot += mCurBet;
        mCurBet = 1;
        for (int i = N2 - 1; i > mCur; i--)
            if (mActive[i]) nxt = i;
        if (nxt >= 0) begin
            mCur = nxt;
        end else begin
            mState = 2;
            for (int i = 0; i < N2; i++)
                if (mActive[i] && mCards[i] > maxCard) maxCard = mCards[i];
            for (int i = 0; i < N2; i++)
                if (mActive[i] && mCards[i] == maxCard) begin holders++; holder = i; end
            mWin = (holders == 1);
            mTie = (holders > 1);
            if (mWin) mWinner = holder;
        end
    endtask

    task automatic modelSettle();
        int alive = 0;
        for (int i = 0; i < N2; i++)
            if (mTie) mChips[i] += mBet[i];
        if (mWin) mChips[mWinner] += mPot;
        for (int i = 0; i < N2; i++) begin
            mBet[i] = 0;
            if (mChips[i] > 0) alive++;
        end
        mPot = 0; mWin = 0; mTie = 0;
        mState = (alive <= 1) ? 3 : 0;
    endtask

    task automatic randomRounds();
        bit u, d, su, sd;
        int presses;
        resetDuts(5);
        modelReset();
        for (int r = 0; r < 12; r++) begin
            mLd = 1'($urandom_range(0, 1));
            cardLd = mLd;
            cardIn2 = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            modelDeal(lfsrAfter(cyc));
            tick();
            checkOutput("rnd deal state", int'(state2), 1);
            checkOutput("rnd card0", card2(0), mCards[0]);
            checkOutput("rnd card1", card2(1), mCards[1]);
            checkOutput("rnd first player", int'(curPlayer2), mCur);
            for (int g = 0; g < N2 && mState == 1; g++) begin
                presses = $urandom_range(0, 12);
                for (int k = 0; k < presses; k++) begin
                    u = ($urandom_range(0, 3) != 0);
                    d = ($urandom_range(0, 2) == 0);
                    applyStimulus(u, d, 1'b0);
                    modelAdjust(u, d);
                    checkOutput("rnd cur_bet", int'(curBet2), mCurBet);
                end
                su = ($urandom_range(0, 3) == 0);
                sd = ($urandom_range(0, 5) == 0);
                applyStimulus(su, sd, 1'b1);
                modelCommit();
                checkOutput("rnd pot", int'(pot2), mPot);
                checkOutput("rnd bet reset", int'(curBet2), 1);
                if (mState == 1) checkOutput("rnd next player", int'(curPlayer2), mCur);
            end
            checkOutput("rnd settle state", int'(state2), 2);
            checkOutput("rnd win_pulse", int'(winPulse2), int'(mWin));
            checkOutput("rnd tie_pulse", int'(tiePulse2), int'(mTie));
            checkOutput("rnd winner", int'(winner2), mWinner);
            tick();
            modelSettle();
            checkOutput("rnd chips0", chip2(0), mChips[0]);
            checkOutput("rnd chips1", chip2(1), mChips[1]);
            checkOutput("rnd pot cleared", int'(pot2), 0);
            checkOutput("rnd post state", int'(state2), mState);
            checkOutput("rnd game_over", int'(gameOver2), int'(mState == 3));
            if (mState == 3) begin
                applyStimulus(1'b1, 1'b0, 1'b1);
                checkOutput("rnd over hold state", int'(state2), 3);
                checkOutput("rnd over hold chips0", chip2(0), mChips[0]);
                break;
            end
        end
    endtask

    // ---------------- directed table for the first two-player round ----------------
    typedef struct {
        logic u;
        logic d;
        logic s;
        int   expBet;
        int   expPlayer;
        int   expPot;
        int   expState;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 3, 0, 0, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1, 1, 3, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 2, 1, 3, 1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1, 1, 5, 2};

        // Reset held long, then deal forced cards P0=7, P1=3
        cardLd = 1'b1;
        cardIn2 = {8'd3, 8'd7};
        resetDuts(100);
        CLR = 1'b1;
        checkOutput("reset chips0", chip2(0), 10);
        checkOutput("reset chips1", chip2(1), 10);
        checkOutput("reset state", int'(state2), 0);
        checkOutput("reset cur_bet", int'(curBet2), 1);
        checkOutput("reset cards", int'(cards2), 0);
        checkOutput("reset pot", int'(pot2), 0);
        CLR = 1'b0;
        tick();
        checkOutput("deal card0", card2(0), 7);
        checkOutput("deal card1", card2(1), 3);
        checkOutput("deal state", int'(state2), 1);
        checkOutput("deal player", int'(curPlayer2), 0);
        checkOutput("deal cur_bet", int'(curBet2), 1);

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].u, vecs[v].d, vecs[v].s);
            checkOutput($sformatf("vec%0d cur_bet", v), int'(curBet2), vecs[v].expBet);
            checkOutput($sformatf("vec%0d pot", v), int'(pot2), vecs[v].expPot);
            checkOutput($sformatf("vec%0d state", v), int'(state2), vecs[v].expState);
            if (vecs[v].expState == 1)
                checkOutput($sformatf("vec%0d player", v), int'(curPlayer2), vecs[v].expPlayer);
        end
        checkOutput("win win_pulse", int'(winPulse2), 1);
        checkOutput("win tie_pulse", int'(tiePulse2), 0);
        checkOutput("win winner", int'(winner2), 0);
        tick();
        checkOutput("win chips0", chip2(0), 12);
        checkOutput("win chips1", chip2(1), 8);
        checkOutput("win pot", int'(pot2), 0);
        checkOutput("win next state", int'(state2), 0);
        checkOutput("win pulse cleared", int'(winPulse2), 0);

        // Tied cards refund both bets
        cardIn2 = {8'd5, 8'd5};
        tick();
        checkOutput("tie deal state", int'(state2), 1);
        checkOutput("tie card1", card2(1), 5);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tie bet0", int'(curBet2), 4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("tie state", int'(state2), 2);
        checkOutput("tie pot", int'(pot2), 5);
        checkOutput("tie tie_pulse", int'(tiePulse2), 1);
        checkOutput("tie win_pulse", int'(winPulse2), 0);
        tick();
        checkOutput("tie chips0", chip2(0), 12);
        checkOutput("tie chips1", chip2(1), 8);
        checkOutput("tie next state", int'(state2), 0);

        // Reset in the middle of betting with chips in the pot
        cardIn2 = {8'd3, 8'd7};
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midbet pot", int'(pot2), 2);
        CLR = 1'b1;
        tick();
        checkOutput("midclr chips0", chip2(0), 10);
        checkOutput("midclr chips1", chip2(1), 10);
        checkOutput("midclr pot", int'(pot2), 0);
        checkOutput("midclr state", int'(state2), 0);
        checkOutput("midclr cur_bet", int'(curBet2), 1);
        CLR = 1'b0;
        tick();
        checkOutput("sat deal state", int'(state2), 1);

        // Saturation at both ends, and a held button counts once
        repeat (15) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sat high", int'(curBet2), 10);
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("sat low", int'(curBet2), 1);
        btnUp = 1'b1;
        repeat (20) tick();
        btnUp = 1'b0;
        repeat (2) tick();
        checkOutput("held up", int'(curBet2), 2);

        // Three players: P2 busts in round one, is skipped in round two, P0 wins all
        cardIn3 = {8'd3, 8'd9, 8'd2};
        resetDuts(3);
        tick();
        checkOutput("n3 deal state", int'(state3), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("n3 player2", int'(curPlayer3), 2);
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("n3 allin bet", int'(curBet3), 10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("n3 r1 state", int'(state3), 2);
        checkOutput("n3 r1 winner", int'(winner3), 1);
        checkOutput("n3 r1 win_pulse", int'(winPulse3), 1);
        tick();
        checkOutput("n3 r1 chips0", chip3(0), 9);
        checkOutput("n3 r1 chips1", chip3(1), 21);
        checkOutput("n3 r1 chips2", chip3(2), 0);
        cardIn3 = {8'd5, 8'd3, 8'd9};
        tick();
        checkOutput("n3 r2 card2", card3(2), 0);
        checkOutput("n3 r2 card0", card3(0), 9);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("n3 r2 player", int'(curPlayer3), 1);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("n3 r2 bet1", int'(curBet3), 21);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("n3 r2 skip to settle", int'(state3), 2);
        tick();
        checkOutput("n3 over state", int'(state3), 3);
        checkOutput("n3 game_over", int'(gameOver3), 1);
        checkOutput("n3 over chips0", chip3(0), 30);
        checkOutput("n3 over chips1", chip3(1), 0);
        checkOutput("n3 over pot", int'(pot3), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("n3 hold state", int'(state3), 3);
        checkOutput("n3 hold bet", int'(curBet3), 1);
        checkOutput("n3 hold chips0", chip3(0), 30);

        randomRounds();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
